mac_result_tx: RTL and testbench

UART 8N1 transmitter that returns 16-bit MAC results to the host over the serial link opposite the receive path. A one-cycle strobe captures a 16-bit word, which is sent as two bytes, high byte first. A one-deep pending register absorbs one result that arrives while a word is still being sent. The block sits between the MAC output and the board TX pin.

---
 rtl/mac_uart_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 108 ++++++++++
 rtl/mac_result_tx.sv | 122 ++++++++++++
 tb/tb_mac_result_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_uart_pkg.sv
// Shared types and constants for the MAC result UART transmit path.
// No timing of its own; no backpressure.
// Holds the serializer state encoding and the byte-order helper.
package mac_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int DATA_BITS        = 8;
    localparam int BYTES_PER_WORD   = 2;
    localparam int DEF_CLKS_PER_BIT = 868;

    // idx 0 is the first byte on the wire; msb_first picks which half that is.
    function automatic logic [7:0] word_byte(input logic [15:0] w,
                                             input logic        idx,
                                             input logic        msb_first);
        return (idx ^ msb_first) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// Latency: start sampled at an edge drives tx low from that edge; 10*CLKS_PER_BIT cycles per byte.
// Backpressure: start is only honoured in IDLE or on the done cycle (back-to-back chaining).
module uart_tx_byte
    import mac_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       done
);

    localparam int                 CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam int                 BIT_W   = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]   BIT_MAX = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shf_q, shf_d;
    logic                 tx_q, tx_d;
    logic                 wrap;

    assign wrap = (cnt_q == CNT_MAX);
    assign done = (state_q == STOP) && wrap;
    assign tx   = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shf_d   = shf_q;
        tx_d    = tx_q;
        if (state_q == IDLE || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = START;
                    shf_d   = byte_in;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shf_q[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == BIT_MAX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        shf_d = shf_q >> 1;
                        tx_d  = shf_q[1];
                    end
                end
            end
            STOP: begin
                // A start on the last stop cycle chains the next byte with no idle gap.
                if (wrap) begin
                    if (start) begin
                        state_d = START;
                        shf_d   = byte_in;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shf_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shf_q   <= shf_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/mac_result_tx.sv
// Sends each captured 16-bit MAC result as two 8N1 bytes on a registered tx line.
// Latency: send high in the cycle before edge k (idle) gives tx low from edge k; 20*CLKS_PER_BIT cycles per word.
// Backpressure: none upstream; one word is buffered in pending, a further send is discarded and flagged on drop.
module mac_result_tx
    import mac_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEF_CLKS_PER_BIT,
    parameter int MSB_BYTE_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [15:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        drop
);

    localparam int               IDX_W     = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic             MSB_FIRST = (MSB_BYTE_FIRST != 0);

    logic             active_q, active_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [15:0]      word_q, word_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             drop_q, drop_d;

    logic             byte_done;
    logic             last_done;
    logic             load;
    logic [15:0]      load_word;
    logic             ser_start;
    logic [7:0]       ser_byte;

    assign last_done = byte_done && (byte_idx_q == LAST_IDX);
    assign busy      = active_q | pend_vld_q;
    assign drop      = drop_q;

    always_comb begin
        active_d   = active_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        drop_d     = 1'b0;
        load       = 1'b0;
        load_word  = data_in;
        ser_start  = 1'b0;
        ser_byte   = word_byte(word_q, byte_idx_q, MSB_FIRST);

        if (last_done) begin
            // End of word: pending goes out next and a coincident send refills the freed slot.
            if (pend_vld_q) begin
                load       = 1'b1;
                load_word  = pend_q;
                pend_vld_d = send;
                if (send) begin
                    pend_d = data_in;
                end
            end else if (send) begin
                load = 1'b1;
            end else begin
                active_d = 1'b0;
            end
        end else if (send) begin
            if (!active_q) begin
                load = 1'b1;
            end else if (!pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_d     = data_in;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (byte_done && !last_done) begin
            byte_idx_d = byte_idx_q + 1'b1;
            ser_start  = 1'b1;
            ser_byte   = word_byte(word_q, byte_idx_d, MSB_FIRST);
        end

        if (load) begin
            active_d   = 1'b1;
            word_d     = load_word;
            byte_idx_d = '0;
            ser_start  = 1'b1;
            ser_byte   = word_byte(load_word, 1'b0, MSB_FIRST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q   <= 1'b0;
            byte_idx_q <= '0;
            word_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            active_q   <= active_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            drop_q     <= drop_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .start  (ser_start),
        .byte_in(ser_byte),
        .tx     (tx),
        .done   (byte_done)
    );

endmodule

// File: tb/tb_mac_result_tx.sv
// Directed bench for mac_result_tx with a word-level line model checked every cycle.
module tb_mac_result_tx;

    localparam int C        = 4;
    localparam int WORD_CYC = 20 * C;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        send0 = 1'b0;
    logic        send1 = 1'b0;
    logic [15:0] din0  = '0;
    logic [15:0] din1  = '0;
    logic        tx0, busy0, drop0;
    logic        tx1, busy1, drop1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mac_result_tx #(.CLKS_PER_BIT(C), .MSB_BYTE_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .send(send0), .data_in(din0),
        .tx(tx0), .busy(busy0), .drop(drop0)
    );

    mac_result_tx #(.CLKS_PER_BIT(C), .MSB_BYTE_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .send(send1), .data_in(din1),
        .tx(tx1), .busy(busy1), .drop(drop1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model of dut0: time offset into the current 20-bit-slot word.
    logic        m_act  = 1'b0;
    logic        m_pv   = 1'b0;
    logic        m_drop = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_word = '0;
    logic [15:0] m_pw   = '0;

    function automatic logic model_tx();
        int         p;
        int         b;
        logic [7:0] by;
        if (!m_act) return 1'b1;
        p  = m_t / C;
        b  = p % 10;
        by = (p < 10) ? m_word[15:8] : m_word[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    always @(posedge clk) begin
        m_drop = 1'b0;
        if (!rst) begin
            m_act = 1'b0;
            m_pv  = 1'b0;
            m_t   = 0;
        end else if (!m_act) begin
            if (send0) begin
                m_act  = 1'b1;
                m_t    = 0;
                m_word = din0;
            end
        end else if (m_t == WORD_CYC - 1) begin
            m_t = 0;
            if (m_pv) begin
                m_word = m_pw;
                m_pv   = send0;
                if (send0) m_pw = din0;
            end else if (send0) begin
                m_word = din0;
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_t++;
            if (send0) begin
                if (!m_pv) begin
                    m_pv = 1'b1;
                    m_pw = din0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end
        #1;
        chk("model_tx", 32'(tx0), 32'(model_tx()));
        chk("model_busy", 32'(busy0), 32'(m_act | m_pv));
        chk("model_drop", 32'(drop0), 32'(m_drop));
    end

    task automatic pulse(input int inst, input logic [15:0] w);
        @(negedge clk);
        if (inst == 0) begin
            send0 = 1'b1;
            din0  = w;
        end else begin
            send1 = 1'b1;
            din1  = w;
        end
        @(negedge clk);
        send0 = 1'b0;
        send1 = 1'b0;
        din0  = ~w;
        din1  = ~w;
    endtask

    // Called right after pulse(); samples mid-bit and counts busy cycles until idle.
    task automatic check_frame(input int inst, input logic [0:19] bits, input int exp_busy);
        int   nb;
        logic t;
        logic b;
        nb = 0;
        t  = 1'b0;
        for (int j = 0; j < 8 * WORD_CYC; j++) begin
            t = (inst == 0) ? tx0 : tx1;
            b = (inst == 0) ? busy0 : busy1;
            if (!b) break;
            nb++;
            if (j % C == 1 && j / C < 20)
                chk($sformatf("frame%0d_bit%0d", inst, j / C), 32'(t), 32'(bits[j / C]));
            @(negedge clk);
        end
        chk($sformatf("frame%0d_busy_cycles", inst), nb, exp_busy);
        chk($sformatf("frame%0d_tx_idle", inst), 32'(t), 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int j = 0; j < max_cyc; j++) begin
            if (!busy0) break;
            @(negedge clk);
        end
        chk("idle_timeout", 32'(busy0), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx0), 1);
        chk("reset_busy", 32'(busy0), 0);
        chk("reset_drop", 32'(drop0), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0x1234: bytes 0x12 then 0x34
        pulse(0, 16'h1234);
        check_frame(0, 20'b0010010001_0001011001, 80);
        repeat (3) @(negedge clk);

        // Reset in the middle of the first byte's data bits
        pulse(0, 16'h2400);
        repeat (8) @(negedge clk);
        chk("pre_reset_tx", 32'(tx0), 0);
        rst = 1'b0;
        #1;
        chk("mid_reset_tx", 32'(tx0), 1);
        chk("mid_reset_busy", 32'(busy0), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse(0, 16'h00FF);
        check_frame(0, 20'b0000000001_0111111111, 80);
        repeat (3) @(negedge clk);

        // Second word arrives mid-frame and follows with no gap
        pulse(0, 16'hA55A);
        fork
            check_frame(0, 20'b0101001011_0010110101, 160);
            begin
                repeat (9) @(negedge clk);
                pulse(0, 16'h0F0F);
            end
        join
        repeat (3) @(negedge clk);

        // Third word while pending is full is dropped
        pulse(0, 16'h1111);
        repeat (4) @(negedge clk);
        pulse(0, 16'h2222);
        repeat (4) @(negedge clk);
        pulse(0, 16'h3333);
        chk("drop_pulse", 32'(drop0), 1);
        @(negedge clk);
        chk("drop_clear", 32'(drop0), 0);
        wait_idle(4 * WORD_CYC);
        repeat (3) @(negedge clk);

        // Send on the final stop cycle with pending empty
        pulse(0, 16'hBEEF);
        lows = 0;
        for (int j = 0; j < WORD_CYC - 2; j++) begin
            @(negedge clk);
            if (!busy0) lows++;
        end
        pulse(0, 16'hCAFE);
        chk("chain_busy_gap", lows, 0);
        chk("chain_start_tx", 32'(tx0), 0);
        chk("chain_start_busy", 32'(busy0), 1);

        // Same boundary with pending full: nothing is dropped
        pulse(0, 16'h1357);
        repeat (WORD_CYC - 4) @(negedge clk);
        pulse(0, 16'h2468);
        chk("full_boundary_drop", 32'(drop0), 0);
        chk("full_boundary_busy", 32'(busy0), 1);
        wait_idle(4 * WORD_CYC);
        repeat (3) @(negedge clk);

        // LSB byte first: 0xA0 then 0xC3
        pulse(1, 16'hC3A0);
        check_frame(1, 20'b0000001011_0110000111, 80);
        chk("lsb_first_drop", 32'(drop1), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
